// File: rtl/fp_pkg.sv
// Shared float helpers for the error-estimate datapath: rounding-mode codes,
// per-width format parameters and raw field extraction from a packed operand.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RUP = 3'd2;
  localparam logic [2:0] RM_RDN = 3'd3;

  function automatic int emsb(input int wid);
    return (wid == 64) ? 10 : 7;
  endfunction

  function automatic int fmsb(input int wid);
    return (wid == 64) ? 51 : 22;
  endfunction

  function automatic int bias(input int wid);
    return (wid == 64) ? 1023 : 127;
  endfunction

  // Operands arrive zero-extended to 64 bits so one helper serves both widths.
  function automatic logic fp_sign(input logic [63:0] x, input int wid);
    return 1'(x >> (wid - 1));
  endfunction

  function automatic logic [10:0] fp_exp_field(input logic [63:0] x, input int wid);
    return 11'((x >> (fmsb(wid) + 1)) & ((64'd1 << (emsb(wid) + 1)) - 64'd1));
  endfunction

  function automatic logic [51:0] fp_frac_field(input logic [63:0] x, input int wid);
    return 52'(x & ((64'd1 << (fmsb(wid) + 1)) - 64'd1));
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Aligns a {1,frac} mantissa to its integer position for unbiased exponent ue,
// returning the integer part, the first dropped bit and the OR of the rest.
module fp_rshift_sticky
  import fp_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic signed [emsb(WID)+1:0] ue,
  input  logic        [fmsb(WID)+1:0] man,
  output logic        [WID-1:0]       int_part,
  output logic                        rnd,
  output logic                        stk
);

  localparam int MW = fmsb(WID) + 2;
  localparam int VW = 2 * WID;
  localparam int SW = $clog2(WID) + 1;

  logic [VW-1:0] aligned;
  logic [VW-1:0] shifted;
  logic [SW-1:0] sh;
  int            ue_i;

  // Mantissa MSB starts at the 2^(WID-1) position; shifting right by WID-1-ue
  // leaves the binary point between the upper and lower WID-bit halves.
  always_comb begin
    ue_i     = int'(ue);
    aligned  = {man, {(VW - MW){1'b0}}};
    sh       = '0;
    shifted  = aligned;
    int_part = '0;
    rnd      = 1'b0;
    stk      = 1'b0;
    if (ue_i < -1) begin
      stk = |man;
    end else begin
      if (ue_i <= WID - 1) sh = SW'(WID - 1 - ue_i);
      shifted  = aligned >> sh;
      int_part = shifted[VW-1:WID];
      rnd      = shifted[WID-1];
      stk      = |shifted[WID-2:0];
    end
  end

endmodule

// File: rtl/float2int.sv
// Three-stage float to saturated signed-integer converter (unpack, align,
// round/saturate); every stage advances only when ce is high.
module float2int
  import fp_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           i_vld,
  input  logic [2:0]     rm,
  input  logic [WID-1:0] i,
  output logic [WID-1:0] o,
  output logic           o_vld,
  output logic           o_ovf,
  output logic           o_inv,
  output logic           o_inexact
);

  localparam int EMSB = emsb(WID);
  localparam int FMSB = fmsb(WID);
  localparam int BIAS = bias(WID);
  localparam int UW   = EMSB + 2;
  localparam int SUMW = WID + 1;

  localparam logic [10:0]    EXP_ONES = 11'((1 << (EMSB + 1)) - 1);
  localparam logic [WID:0]   NEG_LIM  = {2'b01, {(WID - 1){1'b0}}};
  localparam logic [WID:0]   POS_LIM  = {2'b00, {(WID - 1){1'b1}}};
  localparam logic [WID-1:0] INT_MAX  = {1'b0, {(WID - 1){1'b1}}};
  localparam logic [WID-1:0] INT_MIN  = {1'b1, {(WID - 1){1'b0}}};

  logic [63:0] i_ext;
  logic [10:0] exp_f;
  logic [51:0] frac_f;

  always_comb begin
    i_ext  = 64'(i);
    exp_f  = fp_exp_field(i_ext, WID);
    frac_f = fp_frac_field(i_ext, WID);
  end

  logic                 s1_vld, s1_sign, s1_stk, s1_inv, s1_nan;
  logic signed [UW-1:0] s1_ue;
  logic [FMSB+1:0]      s1_man;
  logic [2:0]           s1_rm;

  // Zero and denormal operands collapse to magnitude 0; only their sticky survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
    end else if (ce) begin
      s1_vld  <= i_vld;
      s1_sign <= fp_sign(i_ext, WID);
      s1_ue   <= UW'(int'(exp_f) - BIAS);
      s1_man  <= (exp_f == '0) ? '0 : {1'b1, frac_f[FMSB:0]};
      s1_stk  <= (exp_f == '0) && (frac_f != '0);
      s1_inv  <= (exp_f == EXP_ONES);
      s1_nan  <= (exp_f == EXP_ONES) && (frac_f != '0);
      s1_rm   <= rm;
    end
  end

  logic [WID-1:0] al_int;
  logic           al_r, al_s, pre_ovf;
  int             s1_ue_i;

  fp_rshift_sticky #(.WID(WID)) u_align (
    .ue       (s1_ue),
    .man      (s1_man),
    .int_part (al_int),
    .rnd      (al_r),
    .stk      (al_s)
  );

  // -2^(WID-1) is the only value with ue == WID-1 that still fits.
  always_comb begin
    s1_ue_i = int'(s1_ue);
    pre_ovf = !s1_inv &&
              ((s1_ue_i > WID - 1) ||
               ((s1_ue_i == WID - 1) && !(s1_sign && (s1_man[FMSB:0] == '0))));
  end

  logic           s2_vld, s2_sign, s2_r, s2_s, s2_pre_ovf, s2_inv, s2_nan;
  logic [WID-1:0] s2_mag;
  logic [2:0]     s2_rm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
    end else if (ce) begin
      s2_vld     <= s1_vld;
      s2_sign    <= s1_sign;
      s2_mag     <= al_int;
      s2_r       <= al_r;
      s2_s       <= al_s | s1_stk;
      s2_pre_ovf <= pre_ovf;
      s2_inv     <= s1_inv;
      s2_nan     <= s1_nan;
      s2_rm      <= s1_rm;
    end
  end

  logic            inc, post_ovf, ovf, neg_sat, inexact;
  logic [SUMW-1:0] sum;
  logic [WID-1:0]  mag_r, res;

  always_comb begin
    case (s2_rm)
      RM_RNE:  inc = s2_r & (s2_mag[0] | s2_s);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (s2_r | s2_s) & !s2_sign;
      RM_RDN:  inc = (s2_r | s2_s) & s2_sign;
      default: inc = 1'b0;
    endcase
    sum      = {1'b0, s2_mag} + SUMW'(inc);
    mag_r    = sum[WID-1:0];
    post_ovf = s2_sign ? (sum > NEG_LIM) : (sum > POS_LIM);
    ovf      = !s2_inv && (s2_pre_ovf || post_ovf);
    // NaN saturates positive whatever its sign bit says.
    neg_sat  = s2_inv ? (s2_sign && !s2_nan) : s2_sign;
    if (s2_inv || ovf) res = neg_sat ? INT_MIN : INT_MAX;
    else               res = s2_sign ? -mag_r : mag_r;
    inexact  = (s2_r | s2_s) && !ovf && !s2_inv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o         <= '0;
      o_vld     <= 1'b0;
      o_ovf     <= 1'b0;
      o_inv     <= 1'b0;
      o_inexact <= 1'b0;
    end else if (ce) begin
      o_vld <= s2_vld;
      if (s2_vld) begin
        o         <= res;
        o_ovf     <= ovf;
        o_inv     <= s2_inv;
        o_inexact <= inexact;
      end
    end
  end

endmodule

// File: doc/float2int.md
# float2int

Pipelined IEEE-754 float to signed-integer converter. It is the reverse-direction companion of the int-to-float path in the error-estimate arithmetic datapath. It accepts a single- or double-precision float (selected by `WID`) and returns a saturated two's-complement integer. Rounding is controlled by the shared 3-bit rounding-mode code, and the block reports overflow, invalid and inexact flags. The pipeline is three stages and advances only on clock enable.

## Interface
- `WID`, 32: operand width. 32 selects binary32 (EMSB=7, FMSB=22, bias 127); 64 selects binary64 (EMSB=10, FMSB=51, bias 1023). Any other value is illegal.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `ce` input 1: pipeline advance enable. When low, every stage holds.
- `i_vld` input 1: `i`/`rm` carry a real operand; sampled when `ce`=1.
- `rm` input 3: rounding mode. 0 = nearest-even, 1 = toward zero, 2 = toward +inf, 3 = toward -inf, 4-7 = toward zero.
- `i` input WID: float operand `{sign, exp[EMSB:0], frac[FMSB:0]}`.
- `o` output WID: signed integer result.
- `o_vld` output 1: `o` and the flags hold a result.
- `o_ovf` output 1: finite operand out of integer range; `o` is saturated.
- `o_inv` output 1: operand is NaN or ±inf.
- `o_inexact` output 1: nonzero bits were discarded; not asserted when `o_ovf` or `o_inv` is set.

## Operation
- **S1 (unpack):**
  - Register sign, unbiased exponent `ue = exp - bias` (signed, EMSB+2 bits), and mantissa `{1, frac}`.
  - exp = all-ones gives `inv`.
  - exp = 0 (zero or denormal) forces magnitude 0 and sets sticky = (frac != 0).
  - Register `rm` and the valid bit alongside.
- **S2 (align):**
  - `ue >= WID-1` → pre-overflow, except the exact value -2^(WID-1) (sign=1, ue=WID-1, frac=0), which is legal.
  - `0 <= ue < WID-1` → right-shift the mantissa so that `WID-1` integer bits remain. Produce the integer LSB, round bit r (first dropped bit) and sticky s (OR of all lower dropped bits).
  - `ue < 0` → integer 0. r = 1 only when ue = -1; s = OR of everything else.
- **S3 (round, sign, saturate):**
  - Round increment:
    - mode 0: r & (lsb | s)
    - mode 1: 0
    - mode 2: (r | s) & !sign
    - mode 3: (r | s) & sign
    - modes 4-7: 0
  - Add the increment to a WID-bit magnitude.
  - Post-round overflow when magnitude > 2^(WID-1)-1 (positive) or > 2^(WID-1) (negative).
  - Negate the result if sign = 1.
- **Saturation:**
  - positive overflow, +inf, NaN → 2^(WID-1)-1
  - negative overflow, -inf → -2^(WID-1)
- **Flags:** `o_inexact` = (r | s) & !ovf & !inv. -0.0 gives 0 with no flags.

## Timing
- Latency is 3 `ce`-qualified edges: an operand sampled on edge N (with `ce`=1 throughout) appears on `o` after edge N+2.
- With `ce` held high, throughput is one operand per clock.
- `ce`=0: all data, flag and valid registers hold. `o`/`o_vld` stay stable for any number of cycles.
- `i_vld`=0 with `ce`=1 inserts a bubble. `o_vld` goes low 3 edges later, and `o`/flags keep their last values.
- Reset: `rst_n`=0 at an edge clears all stage valids, `o`, `o_vld` and all flags to 0, regardless of `ce`. In-flight operands are discarded. The first operand accepted at or after the edge where `rst_n` returns high yields `o_vld` 3 edges later.
- `rm` is sampled with its operand and travels with it; changing `rm` mid-stream never affects older operands.

## Structure
- Shared package `fp_pkg` holds:
  - the rounding-mode constants (shared with int-to-float),
  - functions `emsb(WID)`, `fmsb(WID)` and `bias(WID)`,
  - the float field-extract helpers.
- Sub-module `fp_rshift_sticky` (parameter WID): combinational right shift by `ue` that returns the shifted integer, the round bit and sticky. It is instantiated once in S2.
- The top module holds the three pipeline register banks and the valid shift chain.

## Test plan
- WID=32, ce=1, continuous stream:
  - `0x3FC00000` (1.5): rm=0 → 2, rm=1 → 1.
  - `0xBFC00000` (-1.5): rm=3 → `0xFFFFFFFE`, rm=2 → `0xFFFFFFFF`.
  - All four rm values have `o_inexact`=1.
- `0x40200000` (2.5): rm=0 → 2.
  - `0x40600000` (3.5): rm=0 → 4.
  - `0x3E99999A` (0.3): rm=2 → 1, rm=0 → 0.
  - `0x00000001` (denormal): rm=2 → 1, rm=3 → 0, inexact=1.
- `0x4F000000` (2^31) → `0x7FFFFFFF` with o_ovf.
  - `0xCF000000` → `0x80000000`, no flags.
  - `0x7FC00000` → `0x7FFFFFFF` with o_inv.
  - `0xFF800000` → `0x80000000` with o_inv.
- Back-to-back 1.0, 2.0, 3.0 with `ce` dropped for 4 cycles after the second operand:
  - outputs appear as 1, 2, 3, each exactly 3 enabled edges after acceptance;
  - `o`/`o_vld` are frozen during the stall.
- Reset mid-stream (`rst_n`=0 for 1 edge with 2 operands in flight):
  - `o_vld`=0 and `o`=0 on the next cycle;
  - neither operand ever emerges.
- WID=64: `0xC1E0000000000001` (just below -2^31 by 2^-21) with rm=1 → `0xFFFFFFFF80000000`, inexact=1.
